padded_column_streamer: RTL and testbench

//  Parametrised successor to the fixed 24x32 padded-column input stage.

---
 rtl/padded_column_streamer.sv | 185 ++++++++++++++++++
 tb/tb_padded_column_streamer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/padded_column_streamer.sv
// Padded-column input stage: reads one frame from a synchronous-read buffer and streams
// IMG_W+2*PAD padded columns. Optional edge-replicate padding is enabled by PAD_REPLICATE_EN.
module padded_column_streamer #(
    parameter int DATA_W = 8,
    parameter int IMG_H  = 24,
    parameter int IMG_W  = 32,
    parameter int PAD    = 1,
    parameter int AW     = $clog2(IMG_H * IMG_W)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              en,
    input  logic                              frame_rdy,
    input  logic [DATA_W-1:0]                 pad_value,
`ifdef PAD_REPLICATE_EN
    input  logic                              pad_mode,
`endif
    output logic                              frame_release,
    output logic                              mem_rd_en,
    output logic [AW-1:0]                     mem_addr,
    input  logic [DATA_W-1:0]                 mem_rdata,
    output logic [(IMG_H+2*PAD)*DATA_W-1:0]   col_data,
    output logic                              col_vld,
    input  logic                              col_rdy,
    output logic [$clog2(IMG_W+2*PAD)-1:0]    col_idx,
    output logic                              col_last,
    output logic                              busy
);

    localparam int NROW = IMG_H + 2 * PAD;
    localparam int NCOL = IMG_W + 2 * PAD;
    localparam int CW   = $clog2(NCOL);
    localparam int FW   = $clog2(IMG_H + 1);

    localparam logic [CW-1:0] PAD_C      = CW'(PAD);
    localparam logic [CW-1:0] EDGE_C     = CW'(IMG_W + PAD);
    localparam logic [CW-1:0] LAST_COL_C = CW'(NCOL - 1);
    localparam logic [FW-1:0] F_ONE_C    = FW'(1);
    localparam logic [FW-1:0] F_LRD_C    = FW'(IMG_H - 1);
    localparam logic [FW-1:0] F_END_C    = FW'(IMG_H);
    localparam logic [AW-1:0] ROW_STEP_C = AW'(IMG_W);
    localparam logic [AW-1:0] MAX_COL_C  = AW'(IMG_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        NEXT   = 3'd1,
        PADCOL = 3'd2,
        FETCH  = 3'd3,
        HOLD   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t              state_r;
    logic [DATA_W-1:0]   pad_r;
    logic [FW-1:0]       fcnt_r;
    logic                is_pad_s;
    logic                repl_s;
    logic [AW-1:0]       clamp_col_s;

`ifdef PAD_REPLICATE_EN
    logic pad_mode_r;
    assign repl_s = pad_mode_r;
`else
    assign repl_s = 1'b0;
`endif

    // Padded row 0 sits in the MSBs of the flat column vector
    function automatic int row_lsb(input int row);
        return (NROW - 1 - row) * DATA_W;
    endfunction

    // Classify the column about to be produced and clamp it into the image
    always_comb begin
        is_pad_s = (col_idx < PAD_C) || (col_idx >= EDGE_C);
        if (col_idx < PAD_C) begin
            clamp_col_s = '0;
        end else if (col_idx >= EDGE_C) begin
            clamp_col_s = MAX_COL_C;
        end else begin
            clamp_col_s = AW'(col_idx - PAD_C);
        end
    end

    // Column sequencer with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            pad_r         <= '0;
            fcnt_r        <= '0;
            frame_release <= 1'b0;
            mem_rd_en     <= 1'b0;
            mem_addr      <= '0;
            col_data      <= '0;
            col_vld       <= 1'b0;
            col_idx       <= '0;
            col_last      <= 1'b0;
            busy          <= 1'b0;
`ifdef PAD_REPLICATE_EN
            pad_mode_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    frame_release <= 1'b0;
                    if (en && frame_rdy) begin
                        pad_r   <= pad_value;
`ifdef PAD_REPLICATE_EN
                        pad_mode_r <= pad_mode;
`endif
                        col_idx <= '0;
                        busy    <= 1'b1;
                        state_r <= NEXT;
                    end
                end
                NEXT: begin
                    if (is_pad_s && !repl_s) begin
                        state_r <= PADCOL;
                    end else begin
                        col_data  <= {NROW{pad_r}};
                        fcnt_r    <= '0;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= clamp_col_s;
                        state_r   <= FETCH;
                    end
                end
                PADCOL: begin
                    col_data <= {NROW{pad_r}};
                    col_vld  <= 1'b1;
                    col_last <= (col_idx == LAST_COL_C);
                    state_r  <= HOLD;
                end
                FETCH: begin
                    fcnt_r <= fcnt_r + F_ONE_C;
                    // Read data lags the strobe by one cycle, so cycle k captures row k-1
                    if (fcnt_r != '0) begin
                        col_data[row_lsb(int'(fcnt_r) - 1 + PAD) +: DATA_W] <= mem_rdata;
                        if (repl_s && (fcnt_r == F_ONE_C)) begin
                            for (int i = 0; i < PAD; i++) begin
                                col_data[row_lsb(i) +: DATA_W] <= mem_rdata;
                            end
                        end
                        if (repl_s && (fcnt_r == F_END_C)) begin
                            for (int i = IMG_H + PAD; i < NROW; i++) begin
                                col_data[row_lsb(i) +: DATA_W] <= mem_rdata;
                            end
                        end
                    end
                    if (fcnt_r < F_LRD_C) begin
                        mem_addr <= mem_addr + ROW_STEP_C;
                    end else begin
                        mem_rd_en <= 1'b0;
                        mem_addr  <= '0;
                    end
                    if (fcnt_r == F_END_C) begin
                        col_vld  <= 1'b1;
                        col_last <= (col_idx == LAST_COL_C);
                        state_r  <= HOLD;
                    end
                end
                HOLD: begin
                    if (col_rdy) begin
                        col_vld  <= 1'b0;
                        col_last <= 1'b0;
                        if (col_last) begin
                            frame_release <= 1'b1;
                            state_r       <= DONE;
                        end else begin
                            col_idx <= col_idx + CW'(1);
                            state_r <= NEXT;
                        end
                    end
                end
                DONE: begin
                    frame_release <= 1'b0;
                    busy          <= 1'b0;
                    state_r       <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_padded_column_streamer.sv
// Directed bench: default 24x32/PAD=1 instance plus a 4x8/PAD=2 instance for latency
// and (with PAD_REPLICATE_EN) edge-replicate checks.
module tb_padded_column_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    // default instance: 24x32, PAD=1
    logic          d_en, d_frame_rdy, d_col_rdy, d_pad_mode;
    logic [7:0]    d_pad, d_rdata;
    logic          d_release, d_rd_en, d_col_vld, d_col_last, d_busy;
    logic [9:0]    d_addr;
    logic [207:0]  d_col_data;
    logic [5:0]    d_col_idx;

    // small instance: 4x8, PAD=2
    logic          s_en, s_frame_rdy, s_col_rdy, s_pad_mode;
    logic [7:0]    s_pad, s_rdata;
    logic          s_release, s_rd_en, s_col_vld, s_col_last, s_busy;
    logic [4:0]    s_addr;
    logic [63:0]   s_col_data;
    logic [3:0]    s_col_idx;

    int rel_cnt = 0, d_rd_cnt = 0, s_rd_cnt = 0;

    padded_column_streamer u_dut (
        .clk(clk), .rst_n(rst_n), .en(d_en), .frame_rdy(d_frame_rdy), .pad_value(d_pad),
`ifdef PAD_REPLICATE_EN
        .pad_mode(d_pad_mode),
`endif
        .frame_release(d_release), .mem_rd_en(d_rd_en), .mem_addr(d_addr), .mem_rdata(d_rdata),
        .col_data(d_col_data), .col_vld(d_col_vld), .col_rdy(d_col_rdy), .col_idx(d_col_idx),
        .col_last(d_col_last), .busy(d_busy)
    );

    padded_column_streamer #(.DATA_W(8), .IMG_H(4), .IMG_W(8), .PAD(2)) u_small (
        .clk(clk), .rst_n(rst_n), .en(s_en), .frame_rdy(s_frame_rdy), .pad_value(s_pad),
`ifdef PAD_REPLICATE_EN
        .pad_mode(s_pad_mode),
`endif
        .frame_release(s_release), .mem_rd_en(s_rd_en), .mem_addr(s_addr), .mem_rdata(s_rdata),
        .col_data(s_col_data), .col_vld(s_col_vld), .col_rdy(s_col_rdy), .col_idx(s_col_idx),
        .col_last(s_col_last), .busy(s_busy)
    );

    // frame buffers: default mem[a]=a[7:0], small mem[a]=a+16
    always @(posedge clk) begin
        if (d_rd_en) d_rdata <= d_addr[7:0];
        if (s_rd_en) s_rdata <= 8'(s_addr) + 8'h10;
        if (d_release) rel_cnt <= rel_cnt + 1;
        if (d_rd_en) d_rd_cnt <= d_rd_cnt + 1;
        if (s_rd_en) s_rd_cnt <= s_rd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && !d_rd_en) chk("d_addr_idle", d_addr, 0);
        if (rst_n && !s_rd_en) chk("s_addr_idle", s_addr, 0);
    end

    function automatic logic [207:0] exp_d(input int k);
        logic [207:0] v;
        logic [7:0]   px;
        v = '0;
        for (int row = 0; row < 26; row++) begin
            if (k == 0 || k == 33 || row == 0 || row == 25) px = 8'hAA;
            else px = 8'((row - 1) * 32 + (k - 1));
            v[(25 - row) * 8 +: 8] = px;
        end
        return v;
    endfunction

    function automatic logic [63:0] exp_s(input int k, input bit repl);
        logic [63:0] v;
        logic [7:0]  px;
        int c, r;
        v = '0;
        for (int row = 0; row < 8; row++) begin
            c = k - 2;
            if (c < 0) c = 0;
            if (c > 7) c = 7;
            r = row - 2;
            if (r < 0) r = 0;
            if (r > 3) r = 3;
            if (!repl && (k < 2 || k >= 10 || row < 2 || row >= 6)) px = 8'h5C;
            else px = 8'(r * 8 + c + 16);
            v[(7 - row) * 8 +: 8] = px;
        end
        return v;
    endfunction

    task automatic collect_default(input int stall_col);
        int k, guard, rd0;
        logic [207:0] snap_d;
        logic [5:0]   snap_i;
        k = 0;
        guard = 0;
        while (k < 34 && guard < 4000) begin
            @(negedge clk);
            guard++;
            if (d_col_vld) begin
                if (k == stall_col) begin
                    d_col_rdy = 1'b0;
                    snap_d = d_col_data;
                    snap_i = d_col_idx;
                    rd0 = d_rd_cnt;
                    for (int s = 0; s < 50; s++) @(negedge clk);
                    chk("stall_data", d_col_data, snap_d);
                    chk("stall_idx", d_col_idx, snap_i);
                    chk("stall_vld", d_col_vld, 1);
                    chk("stall_rd", d_rd_cnt - rd0, 0);
                    d_col_rdy = 1'b1;
                end
                chk("col_idx", d_col_idx, k);
                chk("col_last", d_col_last, (k == 33));
                chk("col_data", d_col_data, exp_d(k));
                k++;
            end
        end
        chk("frame_cols", k, 34);
    endtask

    task automatic collect_small(input bit repl);
        int k, guard, last_seen, rd_mark;
        k = 0;
        guard = 0;
        last_seen = 0;
        rd_mark = s_rd_cnt;
        while (k < 12 && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (s_col_vld) begin
                if (k == 1) begin
                    chk("lat_col1", guard - last_seen, repl ? 7 : 3);
                    chk("rd_col1", s_rd_cnt - rd_mark, repl ? 4 : 0);
                end
                if (k == 2) begin
                    chk("lat_img", guard - last_seen, 7);
                    chk("rd_img", s_rd_cnt - rd_mark, 4);
                end
                chk("s_col_idx", s_col_idx, k);
                chk("s_col_last", s_col_last, (k == 11));
                chk("s_col_data", s_col_data, exp_s(k, repl));
                last_seen = guard;
                rd_mark = s_rd_cnt;
                k++;
            end
        end
        chk("s_frame_cols", k, 12);
    endtask

    task automatic start_default();
        @(negedge clk);
        d_en = 1'b1;
        d_frame_rdy = 1'b1;
        @(negedge clk);
        d_en = 1'b0;
        d_frame_rdy = 1'b0;
    endtask

    initial begin
        int r0, guard;
        rst_n = 1'b0;
        d_en = 1'b0; d_frame_rdy = 1'b0; d_col_rdy = 1'b1; d_pad = 8'hAA; d_pad_mode = 1'b0;
        s_en = 1'b0; s_frame_rdy = 1'b0; s_col_rdy = 1'b1; s_pad = 8'h5C; s_pad_mode = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {d_release, d_rd_en, d_addr, d_col_vld, d_col_idx, d_col_last, d_busy}, 0);
        chk("reset_data", d_col_data, 0);
        rst_n = 1'b1;

        // full frame, en/frame_rdy dropped mid-frame
        start_default();
        collect_default(-1);
        repeat (4) @(negedge clk);
        chk("t2_release", rel_cnt, 1);
        chk("t2_idle", d_busy, 0);

        // backpressure on column 5
        start_default();
        collect_default(5);
        repeat (4) @(negedge clk);
        chk("t4_release", rel_cnt, 2);

        // back-to-back frames with frame_rdy held high
        @(negedge clk);
        d_en = 1'b1;
        d_frame_rdy = 1'b1;
        collect_default(-1);
        @(negedge clk);
        chk("t5_pulse", d_release, 1);
        @(negedge clk);
        chk("t5_pulse_end", d_release, 0);
        @(negedge clk);
        chk("t5_restart_busy", d_busy, 1);
        chk("t5_restart_idx", d_col_idx, 0);
        d_en = 1'b0;
        d_frame_rdy = 1'b0;
        collect_default(-1);
        repeat (4) @(negedge clk);
        chk("t5_release", rel_cnt, 4);

        // reset in the middle of a fetch
        start_default();
        guard = 0;
        while (!d_rd_en && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("t1_fetch_seen", d_rd_en, 1);
        repeat (3) @(negedge clk);
        r0 = rel_cnt;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t1_ctrl", {d_release, d_rd_en, d_addr, d_col_vld, d_col_idx, d_col_last, d_busy}, 0);
        chk("t1_data", d_col_data, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t1_no_release", rel_cnt - r0, 0);
        chk("t1_idle", d_busy, 0);

        // latency on the 4-row instance
        @(negedge clk);
        s_en = 1'b1;
        s_frame_rdy = 1'b1;
        @(negedge clk);
        s_en = 1'b0;
        s_frame_rdy = 1'b0;
        collect_small(1'b0);
        repeat (4) @(negedge clk);
        chk("t3_idle", s_busy, 0);

`ifdef PAD_REPLICATE_EN
        // edge replicate, PAD=2
        @(negedge clk);
        s_en = 1'b1;
        s_frame_rdy = 1'b1;
        s_pad_mode = 1'b1;
        @(negedge clk);
        s_en = 1'b0;
        s_frame_rdy = 1'b0;
        s_pad_mode = 1'b0;
        collect_small(1'b1);
        repeat (4) @(negedge clk);
        chk("t6_idle", s_busy, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
